mmio_reg_bank: RTL and testbench

Parametrised memory-mapped register bank that replaces the fixed three-register field. It holds NUM_REGS registers of DATA_W bits at consecutive addresses starting at BASE_ADDR. Bus access uses a valid/ready request channel and a valid/ready response channel, with error reporting and per-register read-only protection. A hardware-side update port lets datapath logic write status values, and all register contents are exported continuously.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/mmio_reg_bank_if.sv | 29 ++
 rtl/mmio_addr_decode.sv | 29 ++
 rtl/mmio_reg_bank.sv | 146 ++++++++++++++
 tb/tb_mmio_reg_bank.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared types and sizing helpers for the parametrised MMIO register bank
// and its address decoder.
package mmio_pkg;

    typedef enum logic [0:0] {
        RSP_IDLE = 1'b0,
        RSP_BUSY = 1'b1
    } rsp_state_e;

    // Index width is $clog2(n), but at least 1 so single-register banks still get a port.
    function automatic int idx_width(input int num_regs);
        int w;
        w = $clog2(num_regs);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mmio_reg_bank_if.sv
// Valid/ready request and response channels of the MMIO register bank.
// The master issues requests and consumes responses; the slave is the bank.
interface mmio_reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_addr
    );

endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational window decode: flags addresses inside [BASE_ADDR, BASE_ADDR+NUM_REGS)
// and returns the register index relative to BASE_ADDR.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter  int ADDR_W    = 8,
    parameter  int BASE_ADDR = 48,
    parameter  int NUM_REGS  = 3,
    localparam int IDX_W     = idx_width(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] req_addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // One extra bit keeps BASE_ADDR+NUM_REGS from wrapping at the top of the address space.
    localparam logic [ADDR_W:0] BASE_EXT  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] LIMIT_EXT = (ADDR_W+1)'(BASE_ADDR + NUM_REGS);

    logic [ADDR_W:0] addr_ext_s;

    // Range check and offset extraction.
    always_comb begin
        addr_ext_s = {1'b0, req_addr};
        hit        = (addr_ext_s >= BASE_EXT) && (addr_ext_s < LIMIT_EXT);
        idx        = IDX_W'(addr_ext_s - BASE_EXT);
    end

endmodule

// File: rtl/mmio_reg_bank.sv
// Parametrised memory-mapped register bank with valid/ready bus access,
// per-register read-only protection and a hardware-side update port.
module mmio_reg_bank
    import mmio_pkg::*;
#(
    parameter int                  DATA_W    = 8,
    parameter int                  ADDR_W    = 8,
    parameter int                  NUM_REGS  = 3,
    parameter int                  BASE_ADDR = 48,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    mmio_reg_bank_if.slave               bus,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    localparam int IDX_W = idx_width(NUM_REGS);

    rsp_state_e          state_r;
    rsp_state_e          state_nxt_s;
    logic                accept_s;
    logic                hit_s;
    logic [IDX_W-1:0]    idx_s;
    logic [NUM_REGS-1:0] bus_we_s;
    logic [DATA_W-1:0]   rd_sel_s;
    logic                ro_sel_s;
    logic                rsp_err_s;
    logic [DATA_W-1:0]   rsp_rdata_s;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;
    logic [ADDR_W-1:0]   rsp_addr_r;

    mmio_addr_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .req_addr (bus.req_addr),
        .hit      (hit_s),
        .idx      (idx_s)
    );

    // Response FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RSP_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a fresh accept always leads to a response, even while one is being consumed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RSP_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RSP_BUSY;
                end else begin
                    state_nxt_s = RSP_IDLE;
                end
            end
            RSP_BUSY: begin
                if (accept_s) begin
                    state_nxt_s = RSP_BUSY;
                end else if (bus.rsp_ready) begin
                    state_nxt_s = RSP_IDLE;
                end else begin
                    state_nxt_s = RSP_BUSY;
                end
            end
            default: state_nxt_s = RSP_IDLE;
        endcase
    end

    // FSM outputs and response channel drive.
    always_comb begin
        bus.rsp_valid = (state_r == RSP_BUSY);
        bus.req_ready = (state_r == RSP_IDLE) || bus.rsp_ready;
        bus.rsp_rdata = rsp_rdata_r;
        bus.rsp_err   = rsp_err_r;
        bus.rsp_addr  = rsp_addr_r;
    end

    // Accept, per-register write enables and one-hot read/RO selection by index.
    always_comb begin
        accept_s = bus.req_valid && bus.req_ready;
        bus_we_s = '0;
        rd_sel_s = '0;
        ro_sel_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus_we_s[i] = accept_s && bus.req_write && hit_s &&
                          (idx_s == IDX_W'(i)) && !RO_MASK[i];
            rd_sel_s    = rd_sel_s | (regs_r[i] & {DATA_W{idx_s == IDX_W'(i)}});
            ro_sel_s    = ro_sel_s | (RO_MASK[i] && (idx_s == IDX_W'(i)));
        end
        rsp_err_s   = !hit_s || (bus.req_write && ro_sel_s);
        rsp_rdata_s = (hit_s && !bus.req_write) ? rd_sel_s : {DATA_W{1'b0}};
    end

    // Register storage: bus write wins over the hardware strobe on the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus_we_s[i]) begin
                    regs_r[i] <= bus.req_wdata;
                end else if (hw_we[i]) begin
                    regs_r[i] <= hw_wdata[i*DATA_W +: DATA_W];
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Response payload is captured only on accept, so it holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_addr_r  <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            rsp_addr_r  <= bus.req_addr;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
            rsp_addr_r  <= rsp_addr_r;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs_r[g];
    end

endmodule

// File: tb/tb_mmio_reg_bank.sv
// Scoreboard testbench for mmio_reg_bank (NUM_REGS=3, BASE_ADDR=48, RO_MASK=3'b100).
module tb_mmio_reg_bank;

    localparam logic [2:0] RO = 3'b100;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic [7:0] addr;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  hw_we;
    logic [23:0] hw_wdata;
    logic [23:0] reg_q;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q [$];
    logic [7:0] mdl [3];

    mmio_reg_bank_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mmio_reg_bank #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .NUM_REGS  (3),
        .BASE_ADDR (48),
        .RO_MASK   (RO),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hw_we    (hw_we),
        .hw_wdata (hw_wdata),
        .reg_q    (reg_q)
    );

    always #5 clk = ~clk;

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b addr=%0d, required none",
                         bus.rsp_rdata, bus.rsp_err, bus.rsp_addr);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_addr} !== e) begin
                    failures++;
                    $display("FAIL rsp_payload: got rdata=%h err=%b addr=%0d, required rdata=%h err=%b addr=%0d",
                             bus.rsp_rdata, bus.rsp_err, bus.rsp_addr, e.rdata, e.err, e.addr);
                end
            end
        end
    end

    // One request (optionally with simultaneous hw strobes), starting at posedge+1.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [2:0] hwe, input logic [23:0] hwd);
        rsp_t        e;
        int          idx;
        int          bus_idx;
        logic        hit;
        logic [23:0] exp_v;
        idx     = int'(addr) - 48;
        hit     = (addr >= 8'd48) && (addr < 8'd51);
        bus_idx = -1;
        e.addr  = addr;
        e.rdata = 8'h00;
        e.err   = 1'b0;
        if (!hit) begin
            e.err = 1'b1;
        end else if (wr) begin
            if (RO[idx]) e.err = 1'b1;
            else         bus_idx = idx;
        end else begin
            e.rdata = mdl[idx];
        end
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        hw_we         = hwe;
        hw_wdata      = hwd;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_at_issue: got %b, required 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        hw_we         = 3'b000;
        if (bus_idx >= 0) mdl[bus_idx] = wdata;
        for (int i = 0; i < 3; i++) begin
            if (hwe[i] && (i != bus_idx)) mdl[i] = hwd[i*8 +: 8];
        end
        for (int i = 0; i < 3; i++) exp_v[i*8 +: 8] = mdl[i];
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_valid_after_accept: got %b, required 1", bus.rsp_valid);
        end
        checks++;
        if (reg_q !== exp_v) begin
            failures++;
            $display("FAIL reg_q_after_req: got %h, required %h", reg_q, exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_addr} !== 18'd0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b addr=%0d, required all 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_addr);
        end
        checks++;
        if (reg_q !== 24'h000000) begin
            failures++;
            $display("FAIL reset_reg_q: got %h, required 000000", reg_q);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_basic();
        issue(1'b0, 8'd48, 8'h00, 3'b000, 24'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 8'd49, 8'hA5, 3'b000, 24'h0);
        checks++;
        if (reg_q[15:8] !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_write_visible: got %h, required a5", reg_q[15:8]);
        end
        issue(1'b0, 8'd49, 8'h00, 3'b000, 24'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        issue(1'b1, 8'd51, 8'hFF, 3'b000, 24'h0);
        issue(1'b0, 8'd47, 8'h00, 3'b000, 24'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_ro();
        issue(1'b1, 8'd50, 8'h3C, 3'b000, 24'h0);
        hw_we    = 3'b100;
        hw_wdata = 24'h770000;
        @(posedge clk);
        #1;
        hw_we  = 3'b000;
        mdl[2] = 8'h77;
        checks++;
        if (reg_q[23:16] !== 8'h77) begin
            failures++;
            $display("FAIL ro_hw_update: got %h, required 77", reg_q[23:16]);
        end
    endtask

    task automatic test_collision();
        issue(1'b1, 8'd48, 8'h11, 3'b001, 24'h000022);
        checks++;
        if (reg_q[7:0] !== 8'h11) begin
            failures++;
            $display("FAIL collision_bus_wins: got %h, required 11", reg_q[7:0]);
        end
        issue(1'b0, 8'd49, 8'h00, 3'b010, 24'h005500);
        checks++;
        if (reg_q[15:8] !== 8'h55) begin
            failures++;
            $display("FAIL collision_hw_after_read: got %h, required 55", reg_q[15:8]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold_and_reset();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'd48, 8'h00, 3'b000, 24'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_handshake: got req_ready=%b rsp_valid=%b, required 0/1",
                         bus.req_ready, bus.rsp_valid);
            end
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_addr} !== {8'h11, 1'b0, 8'd48}) begin
                failures++;
                $display("FAIL hold_stable: got rdata=%h err=%b addr=%0d, required 11/0/48",
                         bus.rsp_rdata, bus.rsp_err, bus.rsp_addr);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_rsp: got rsp_valid=%b req_ready=%b, required 0/1",
                     bus.rsp_valid, bus.req_ready);
        end
        checks++;
        if (reg_q !== 24'h000000) begin
            failures++;
            $display("FAIL midreset_regs: got %h, required 000000", reg_q);
        end
        checks++;
        if (exp_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_pending: got %0d pending, required 1", exp_q.size());
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) mdl[i] = 8'h00;
        @(negedge clk);
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 8'd48, 8'h00, 3'b000, 24'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd0;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        hw_we         = 3'b000;
        hw_wdata      = 24'h0;
        for (int i = 0; i < 3; i++) mdl[i] = 8'h00;
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_errors();
        test_ro();
        test_collision();
        test_hold_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
